// File: rtl/shift_add_mult32_pkg.sv
// Shared widths and FSM encoding for the 32x32 shift-and-add multiplier.
package shift_add_mult32_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 6;

    // One RUN edge per multiplier bit; the last RUN edge is seen with cnt at OP_W-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult32_adder.sv
// 64-bit ripple-carry adder built from a chain of one-bit full adders.
module FullAdder64
    import shift_add_mult32_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    output logic [PROD_W-1:0] sum
);

    logic [PROD_W-1:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < PROD_W; gi++) begin : g_bit
            assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
            // The carry out of the top bit is dropped: the sum is modulo 2^64.
            if (gi < PROD_W - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
            end
        end
    endgenerate

endmodule

// File: rtl/shift_add_mult32.sv
// Sequential 32x32 unsigned multiplier: one multiplier bit per cycle, fixed
// 32-cycle RUN phase, registered product and handshake outputs.
module shift_add_mult32
    import shift_add_mult32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_t            state_r;
    logic [PROD_W-1:0] acc_r;
    logic [PROD_W-1:0] mcand_r;
    logic [OP_W-1:0]   mplier_r;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] product_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;

    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] acc_next;

    FullAdder64 u_add (
        .a   (acc_r),
        .b   (mcand_r),
        .sum (sum)
    );

    assign acc_next = mplier_r[0] ? sum : acc_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            acc_r     <= '0;
            mcand_r   <= '0;
            mplier_r  <= '0;
            cnt       <= '0;
            product_r <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= {{(PROD_W-OP_W){1'b0}}, a};
                        mplier_r <= b;
                        acc_r    <= '0;
                        cnt      <= '0;
                        state_r  <= RUN;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                RUN: begin
                    acc_r    <= acc_next;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt      <= cnt + 1'b1;
                    // No early exit on a zero multiplier keeps latency constant.
                    if (cnt == CNT_LAST) begin
                        product_r <= acc_next;
                        state_r   <= DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = ready_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: doc/shift_add_mult32.md
SHIFT_ADD_MULT32 -- requirements
Module: shift_add_mult32

Interface
REQ-001 SHALL have no parameters; operand width 32 and product width 64 are fixed.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; it is sampled only when ready=1.
REQ-005 SHALL have port a, input, 32, the unsigned multiplicand, captured on an accepted start.
REQ-006 SHALL have port b, input, 32, the unsigned multiplier, captured on an accepted start.
REQ-007 SHALL have port ready, output, 1, high only in IDLE.
REQ-008 SHALL have port busy, output, 1, high only in RUN.
REQ-009 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port product, output, 64, a registered unsigned result.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 at edge E0, it SHALL:
- load mcand_r <= {32'b0, a}
- load mplier_r <= b
- clear acc_r to 0 and cnt to 0
- go to RUN.
REQ-013 In IDLE with start=0, it SHALL hold all registers.
REQ-014 On each RUN edge, it SHALL:
- set acc_r <= acc_r + mcand_r when mplier_r[0]=1, else hold acc_r
- shift mcand_r left by 1 (zero-fill)
- shift mplier_r right by 1 (zero-fill)
- increment cnt.
REQ-015 The acc_r + mcand_r addition SHALL be 64-bit modulo 2^64; overflow cannot occur for 32x32 operands, and there is no carry-out port.
REQ-016 RUN SHALL last exactly 32 edges (E1..E32) regardless of operand values; there is no early termination.
REQ-017 At E32, it SHALL load product with the final accumulated value and go to DONE.
REQ-018 done SHALL be 1 for exactly the cycle after E32; at E33 the FSM SHALL return to IDLE.
REQ-019 Fixed latency SHALL be: done high 33 cycles after the accepting edge, and ready high again at E33.
REQ-020 start SHALL be ignored in RUN and DONE; operands and state are unaffected.
REQ-021 product SHALL hold its previous value through IDLE, RUN and DONE until the next completion, and is never cleared except by reset.
REQ-022 a and b SHALL be don't-care except at the accepting edge.
REQ-023 Back-to-back operation: start held high through DONE SHALL be accepted at the first IDLE edge (E34), giving one operation per 34 cycles.

Reset
REQ-024 rst=1 at any edge SHALL force:
- state IDLE
- acc_r, mcand_r, mplier_r, cnt and product to 0
- ready=1, busy=0, done=0.
REQ-025 Reset during RUN or DONE SHALL abandon the operation without producing a done pulse.
REQ-026 rst SHALL take priority over start on the same edge.

Structure
REQ-027 A shared package SHALL hold:
- OP_W=32, PROD_W=64, CNT_W=6
- the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
REQ-028 The 64-bit accumulate add SHALL be an instance of the existing 64-bit ripple adder FullAdder64, with inputs acc_r and mcand_r; its output feeds the acc_r next-state mux.
REQ-029 FSM, counter and shift registers SHALL reside in shift_add_mult32; no other sub-modules.

Verification
REQ-030 Small operands: a=3, b=5, start one cycle -> done pulse 33 cycles later, product=64'h0000_0000_0000_000F, ready=1 next cycle.
REQ-031 Maximum operands: a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001.
REQ-032 Zero and shift cases:
- a=32'h1234_5678, b=0 -> product=0, still 33-cycle latency
- a=32'h8000_0000, b=2 -> product=64'h0000_0001_0000_0000.
REQ-033 Start ignored while busy: start, a=7, b=9; then start with a=1, b=1 pulsed during RUN -> single done, product=63, no second operation.
REQ-034 Reset mid-run: rst asserted at E10 of a 3x5 run -> no done; product=0, ready=1 next cycle; a new 2x2 start -> product=4.
REQ-035 Random: 1000 random operand pairs with start held high -> each product equals a*b, and every done pulse is spaced 34 cycles apart.
